// File: rtl/bp_be_pkg.sv
// Shared types for the BE rollback queue.
// The scheduler drives commit/replay/discard as one packed bundle.
package bp_be_pkg;

    typedef struct packed {
        logic clr;
        logic roll;
        logic deq;
    } bp_be_rq_ctrl_s;

endpackage

// File: rtl/bp_be_rollback_queue_ptrs.sv
// Write / read / commit pointers of the rollback queue.
// Pointers carry a wrap bit in the MSB; index is the low bits.
// Within a cycle: yumi/enq first, then deq, then roll, then clr.
module bp_be_rollback_queue_ptrs
    import bp_be_pkg::*;
#(
    parameter  int els_p = 16,
    localparam int ptr_w = $clog2(els_p) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enq_i,
    input  logic             yumi_i,
    input  bp_be_rq_ctrl_s   ctrl_i,
    output logic [ptr_w-2:0] widx_o,
    output logic [ptr_w-2:0] ridx_o,
    output logic             full_o,
    output logic             unread_o,
    output logic             empty_o,
    output logic [ptr_w-1:0] count_o
);

    logic [ptr_w-1:0] wptr_r, rptr_r, cptr_r;
    logic [ptr_w-1:0] wptr_n, rptr_n, cptr_n;
    logic [ptr_w-1:0] w_enq, r_yumi;

    // Next-pointer resolution in precedence order.
    always_comb begin
        w_enq  = wptr_r + ptr_w'(enq_i);
        r_yumi = rptr_r + ptr_w'(yumi_i);
        cptr_n = cptr_r + ptr_w'(ctrl_i.deq);
        rptr_n = ctrl_i.roll ? cptr_n : r_yumi;  // roll voids a same-cycle yumi
        wptr_n = ctrl_i.clr  ? rptr_n : w_enq;   // clr drops a same-cycle enqueue
    end

    // Pointer registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cptr_r <= '0;
        end else begin
            wptr_r <= wptr_n;
            rptr_r <= rptr_n;
            cptr_r <= cptr_n;
        end
    end

    assign widx_o   = wptr_r[ptr_w-2:0];
    assign ridx_o   = rptr_r[ptr_w-2:0];
    assign full_o   = (wptr_r[ptr_w-2:0] == cptr_r[ptr_w-2:0])
                    & (wptr_r[ptr_w-1] != cptr_r[ptr_w-1]);
    assign unread_o = (rptr_r != wptr_r);
    assign empty_o  = (wptr_r == cptr_r);
    assign count_o  = wptr_r - cptr_r;

    // Commit needs a read-but-uncommitted entry (counting a same-cycle yumi).
    a_deq_legal: assert property (@(posedge clk_i) disable iff (reset_i)
        ctrl_i.deq |-> (cptr_r != r_yumi));

endmodule

// File: rtl/bsg_mem_1r1w.sv
// Register-file storage: synchronous write, asynchronous read.
module bsg_mem_1r1w #(
    parameter  int width_p = 64,
    parameter  int els_p   = 16,
    localparam int addr_w  = $clog2(els_p)
) (
    input  logic               w_clk_i,
    input  logic               w_v_i,
    input  logic [addr_w-1:0]  w_addr_i,
    input  logic [width_p-1:0] w_data_i,
    input  logic [addr_w-1:0]  r_addr_i,
    output logic [width_p-1:0] r_data_o
);

    logic [width_p-1:0] mem [els_p];

    // Write port: one entry per cycle on w_v_i.
    always_ff @(posedge w_clk_i) begin
        if (w_v_i) mem[w_addr_i] <= w_data_i;
    end

    assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bp_be_rollback_queue.sv
// Speculative FIFO for the BE issue path: entries are issued via yumi,
// held until committed by deq, replayable by roll, unread tail dropped by clr.
// Optional feature macro: BP_BE_ROLLBACK_QUEUE_BYPASS_EN (same-cycle
// enqueue-to-output bypass when no unread entries are held).
module bp_be_rollback_queue
    import bp_be_pkg::*;
#(
    parameter  int width_p = 64,
    parameter  int els_p   = 16,
    localparam int ptr_w   = $clog2(els_p) + 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i,
    input  logic               deq_i,
    input  logic               roll_i,
    input  logic               clr_i,
    output logic               empty_o,
    output logic [ptr_w-1:0]   count_o
);

    bp_be_rq_ctrl_s   ctrl;
    logic [ptr_w-2:0] widx, ridx;
    logic             full, unread, enq;
    logic [width_p-1:0] mem_data;

    assign ctrl    = '{clr: clr_i, roll: roll_i, deq: deq_i};
    assign ready_o = ~full;
    assign enq     = v_i & ready_o;

    bp_be_rollback_queue_ptrs #(.els_p(els_p)) ptrs (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .enq_i    (enq),
        .yumi_i   (yumi_i),
        .ctrl_i   (ctrl),
        .widx_o   (widx),
        .ridx_o   (ridx),
        .full_o   (full),
        .unread_o (unread),
        .empty_o  (empty_o),
        .count_o  (count_o)
    );

    // Every accepted entry is stored, bypassed or not, so it can be replayed.
    bsg_mem_1r1w #(.width_p(width_p), .els_p(els_p)) mem (
        .w_clk_i  (clk_i),
        .w_v_i    (enq),
        .w_addr_i (widx),
        .w_data_i (data_i),
        .r_addr_i (ridx),
        .r_data_o (mem_data)
    );

`ifdef BP_BE_ROLLBACK_QUEUE_BYPASS_EN
    logic bypass;
    // Nothing unread: forward the incoming entry straight to the consumer.
    assign bypass = ~unread & ~clr_i & ~roll_i & enq;
    assign v_o    = unread | bypass;
    assign data_o = bypass ? data_i : mem_data;
`else
    assign v_o    = unread;
    assign data_o = mem_data;
`endif

    a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
        yumi_i |-> v_o);

endmodule
